lut_truth_table_sweeper: RTL

Readback counterpart to the generated LogicNets LUT neurons (IN_BITS-input, OUT_BITS-output ROM lookups). On request, drives every input code 0..2^IN_BITS-1 into a neuron, captures each output, and packs the results into one truth-table word. The word is returned on a valid/ready interface. Used for post-synthesis table verification and on-chip self-check of the latency-opt neuron layers.

---
 rtl/lut_sweep_pkg.sv | 23 ++
 rtl/lut_sweep_tag_pipe.sv | 56 +++++
 rtl/lut_truth_table_sweeper.sv | 108 ++++++++++
 3 files changed

// File: rtl/lut_sweep_pkg.sv
// Shared types and sizing helpers for the LUT truth-table sweeper.
// Imported by the sweeper top and its tag pipeline.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    HOLD
  } sweep_state_e;

  localparam int IN_BITS_DEF = 6;
  localparam int NUM_CODES = 2 ** IN_BITS_DEF;

  function automatic int num_codes(int in_bits);
    return 2 ** in_bits;
  endfunction

  function automatic int tbl_width(int in_bits, int out_bits);
    return (2 ** in_bits) * out_bits;
  endfunction

endpackage

// File: rtl/lut_sweep_tag_pipe.sv
// Shift register carrying {valid, index} alongside the neuron's latency.
// Depth 0 degenerates to a wire.
module lut_sweep_tag_pipe #(
  parameter int DEPTH = 0,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          any_valid
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst_n, flush};
    assign out_valid = in_valid;
    assign out_idx   = in_idx;
    assign any_valid = in_valid;
  end else begin : g_regs
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [IW-1:0]    idx_q [DEPTH];
    logic [IW-1:0]    idx_d [DEPTH];

    always_comb begin
      v_d[0]   = in_valid;
      idx_d[0] = in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]   = v_q[i-1];
        idx_d[i] = idx_q[i-1];
      end
      if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int i = 0; i < DEPTH; i++)
          idx_q[i] <= '0;
      end else begin
        v_q <= v_d;
        for (int i = 0; i < DEPTH; i++)
          idx_q[i] <= idx_d[i];
      end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];
    assign any_valid = in_valid | (|v_q);
  end

endmodule

// File: rtl/lut_truth_table_sweeper.sv
// Drives every input code into a LUT neuron and packs the responses
// into a single truth-table word returned over valid/ready.
module lut_truth_table_sweeper
  import lut_sweep_pkg::*;
#(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 1,
  parameter int LUT_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 abort,
  output logic [IN_BITS-1:0]   lut_addr,
  input  logic [OUT_BITS-1:0]  lut_data,
  output logic                 tbl_valid,
  input  logic                 tbl_ready,
  output logic [tbl_width(IN_BITS, OUT_BITS)-1:0] tbl_data,
  output logic                 busy
);

  localparam int TW = tbl_width(IN_BITS, OUT_BITS);
  localparam int NC = num_codes(IN_BITS);
  localparam logic [IN_BITS:0] LAST = (IN_BITS+1)'(NC - 1);

  sweep_state_e     state_q, state_d;
  logic [IN_BITS:0] cnt_q, cnt_d;
  logic [TW-1:0]    tbl_q, tbl_d;

  logic               abort_act;
  logic               tag_in_v;
  logic               tag_out_v;
  logic [IN_BITS-1:0] tag_out_idx;
  logic               tag_any;

  assign abort_act = abort &
    ((state_q == SWEEP) | (state_q == DRAIN));
  assign tag_in_v = (state_q == SWEEP);

  lut_sweep_tag_pipe #(
    .DEPTH (LUT_LATENCY),
    .IW    (IN_BITS)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_act),
    .in_valid  (tag_in_v),
    .in_idx    (cnt_q[IN_BITS-1:0]),
    .out_valid (tag_out_v),
    .out_idx   (tag_out_idx),
    .any_valid (tag_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    if (tag_out_v)
      tbl_d[int'(tag_out_idx)*OUT_BITS +: OUT_BITS] = lut_data;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d = SWEEP;
          cnt_d   = '0;
          tbl_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) state_d = DRAIN;
        else cnt_d = cnt_q + 1'b1;
      end
      DRAIN: begin
        if (!tag_any) state_d = HOLD;
      end
      HOLD: begin
        if (tbl_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
    // Abort overrides any same-cycle completion.
    if (abort_act) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
    end
  end

  assign lut_addr    = cnt_q[IN_BITS-1:0];
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tbl_valid   = (state_q == HOLD);
  assign tbl_data    = tbl_q;

endmodule
